// File: rtl/cache_axi_bridge_if.sv
// Signal bundle between a cache controller and an AXI memory port.
// The master modport is the bridge's view; the slave modport is the surrounding environment.
interface cache_axi_bridge_if;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;

    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic         bvalid;
    logic         bready;

    modport master (
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output wr_rdy,
        output araddr, arlen, arvalid,
        input  arready, rdata, rlast, rvalid,
        output rready,
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready, bvalid,
        output bready
    );

    modport slave (
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  wr_rdy,
        input  araddr, arlen, arvalid,
        output arready, rdata, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready, bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_axi_bridge.sv
// Converts cache line/word read and write requests into AXI INCR bursts.
// Independent read and write engines; reads to a line with a write in flight are held off.
module cache_axi_bridge (
    input  logic               clk_g,
    input  logic               reset,
    cache_axi_bridge_if.master bus
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LINE_W  = 128;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned TAG_LSB = 4;
    localparam logic [2:0]       TYPE_LINE = 3'b100;
    localparam logic [LEN_W-1:0] LEN_LINE  = LEN_W'(3);
    localparam logic [LEN_W-1:0] LEN_WORD  = LEN_W'(0);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

    r_state_t r_state_q, r_state_d;
    w_state_t w_state_q, w_state_d;

    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [ADDR_W-1:0] araddr_q, awaddr_q;
    logic [LEN_W-1:0]  arlen_q, awlen_q;
    logic [LINE_W-1:0] wbuf_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [WORD_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic rd_hazard_c, rd_rdy_c, rd_fire_c, wr_rdy_c, wr_fire_c, w_beat_c, w_last_beat_c;

    // Request acceptance and same-line hazard detection
    always_comb begin
        rd_hazard_c = 1'b0;
        if ((w_state_q != W_IDLE) &&
            (bus.rd_addr[ADDR_W-1:TAG_LSB] == awaddr_q[ADDR_W-1:TAG_LSB]))
            rd_hazard_c = 1'b1;
        if (bus.wr_req && (bus.wr_addr[ADDR_W-1:TAG_LSB] == bus.rd_addr[ADDR_W-1:TAG_LSB]))
            rd_hazard_c = 1'b1;
        rd_rdy_c      = (r_state_q == R_IDLE) && !rd_hazard_c;
        rd_fire_c     = bus.rd_req && rd_rdy_c;
        wr_rdy_c      = (w_state_q == W_IDLE);
        wr_fire_c     = bus.wr_req && wr_rdy_c;
        w_beat_c      = wvalid_q && bus.wready;
        w_last_beat_c = (cnt_q == awlen_q[CNT_W-1:0]);
    end

    // Read engine next state
    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (rd_fire_c)                  r_state_d = R_AR;
            R_AR:    if (arvalid_q && bus.arready)   r_state_d = R_DATA;
            R_DATA:  if (bus.rvalid && bus.rlast)    r_state_d = R_IDLE;
            default:                                 r_state_d = R_IDLE;
        endcase
    end

    // Write engine next state and beat counter
    always_comb begin
        w_state_d = w_state_q;
        cnt_d     = cnt_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (wr_fire_c) begin
                    w_state_d = W_AW;
                    cnt_d     = '0;
                end
            end
            W_AW:   if (awvalid_q && bus.awready) w_state_d = W_DATA;
            W_DATA: begin
                if (w_beat_c) begin
                    if (w_last_beat_c) w_state_d = W_RESP;
                    else               cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            W_RESP: if (bready_q && bus.bvalid) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // State and handshake-control registers; valids follow the next state so they never see ready combinationally
    always_ff @(posedge clk_g) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            cnt_q     <= cnt_d;
            arvalid_q <= (r_state_d == R_AR);
            rready_q  <= (r_state_d == R_DATA);
            awvalid_q <= (w_state_d == W_AW);
            wvalid_q  <= (w_state_d == W_DATA);
            wlast_q   <= (w_state_d == W_DATA) && (cnt_d == awlen_q[CNT_W-1:0]);
            bready_q  <= (w_state_d == W_RESP);
        end
    end

    // Request payload capture and write-beat selection
    always_ff @(posedge clk_g) begin
        if (rd_fire_c) begin
            araddr_q <= bus.rd_addr;
            arlen_q  <= (bus.rd_type == TYPE_LINE) ? LEN_LINE : LEN_WORD;
        end
        if (wr_fire_c) begin
            awaddr_q <= bus.wr_addr;
            awlen_q  <= (bus.wr_type == TYPE_LINE) ? LEN_LINE : LEN_WORD;
            wbuf_q   <= bus.wr_data;
            wstrb_q  <= (bus.wr_type == TYPE_LINE) ? STRB_W'(4'hF) : bus.wr_wstrb;
        end
        wdata_q <= wbuf_q[{cnt_d, 5'b0} +: WORD_W];
    end

    assign bus.rd_rdy    = rd_rdy_c;
    assign bus.wr_rdy    = wr_rdy_c;
    assign bus.ret_valid = rready_q && bus.rvalid;
    assign bus.ret_last  = rready_q && bus.rlast;
    assign bus.ret_data  = bus.rdata;

    assign bus.araddr  = araddr_q;
    assign bus.arlen   = arlen_q;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    assign bus.awaddr  = awaddr_q;
    assign bus.awlen   = awlen_q;
    assign bus.awvalid = awvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wlast   = wlast_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = bready_q;
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Randomized bench for cache_axi_bridge: word-addressed memory reference model, AXI slave
// responder and an output monitor that checks against expectation queues.
module tb_cache_axi_bridge;
    logic clk_g = 1'b0;
    logic reset = 1'b1;
    always #5 clk_g = ~clk_g;

    cache_axi_bridge_if bus();
    cache_axi_bridge dut (.clk_g(clk_g), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0] rmem [int unsigned];
    logic [31:0] smem [int unsigned];

    logic [39:0] exp_ar[$], exp_aw[$];
    logic [32:0] exp_ret[$];
    logic [36:0] exp_w[$];
    logic [39:0] s_rq[$], s_wq[$];

    logic        rd_busy = 1'b0, wr_busy = 1'b0;
    logic [27:0] rd_line = '0, wr_line = '0;
    int          w_fires = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned w);
        return w * 32'h9E3779B1 + 32'h1357;
    endfunction
    function automatic logic [31:0] ref_rd(input int unsigned w);
        if (rmem.exists(w)) return rmem[w];
        return init_word(w);
    endfunction
    function automatic logic [31:0] slv_rd(input int unsigned w);
        if (smem.exists(w)) return smem[w];
        return init_word(w);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction
    function automatic logic [31:0] pick_line();
        logic [31:0] base;
        base = ($urandom_range(0, 1) == 1) ? 32'h1C000000 : 32'h80000000;
        return base + 32'($urandom_range(0, 3)) * 32'h40;
    endfunction

    // Reference model: memory image updated when a write is accepted
    task automatic model_write(input logic [31:0] a, input logic line, input logic [3:0] s, input logic [127:0] d);
        int unsigned w;
        w = a >> 2;
        exp_aw.push_back({a, line ? 8'd3 : 8'd0});
        if (line) begin
            for (int i = 0; i < 4; i++) begin
                rmem[w + i] = d[i*32 +: 32];
                exp_w.push_back({(i == 3), 4'hF, d[i*32 +: 32]});
            end
        end else begin
            rmem[w] = merge(ref_rd(w), d[31:0], s);
            exp_w.push_back({1'b1, s, d[31:0]});
        end
        wr_busy = 1'b1;
        wr_line = a[31:4];
    endtask

    task automatic model_read(input logic [31:0] a, input logic line);
        int unsigned w;
        int n;
        w = a >> 2;
        n = line ? 4 : 1;
        exp_ar.push_back({a, line ? 8'd3 : 8'd0});
        for (int i = 0; i < n; i++) exp_ret.push_back({(i == n - 1), ref_rd(w + i)});
        rd_busy = 1'b1;
        rd_line = a[31:4];
    endtask

    task automatic drain();
        int pending;
        for (int k = 0; k < 3000; k++) begin
            pending = int'(rd_busy) + int'(wr_busy) + exp_ar.size() + exp_aw.size() + exp_ret.size() + exp_w.size();
            if (pending == 0) break;
            @(negedge clk_g);
        end
        pending = int'(rd_busy) + int'(wr_busy) + exp_ar.size() + exp_aw.size() + exp_ret.size() + exp_w.size();
        check("drain_pending", 64'(pending), 64'd0);
    endtask

    // AXI slave responder with randomized ready/valid timing
    logic        r_fired = 1'b0, b_fired = 1'b0;
    int          s_rbeat = 0, s_wbeat = 0, s_bpend = 0;
    initial begin
        logic [39:0] cur;
        int unsigned widx;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        forever begin
            @(negedge clk_g);
            bus.arready = ($urandom_range(0, 3) == 0);
            if (r_fired) bus.rvalid = 1'b0;
            r_fired = 1'b0;
            if (!bus.rvalid) begin
                if (s_rq.size() > 0 && $urandom_range(0, 2) != 0) begin
                    cur = s_rq[0];
                    bus.rvalid = 1'b1;
                    bus.rdata  = slv_rd((cur[39:8] >> 2) + s_rbeat);
                    bus.rlast  = (s_rbeat == int'(cur[7:0]));
                end else begin
                    bus.rdata = $urandom;
                    bus.rlast = ($urandom_range(0, 1) == 1);
                end
            end
            bus.awready = ($urandom_range(0, 2) == 0);
            bus.wready  = ($urandom_range(0, 1) == 1);
            if (b_fired) bus.bvalid = 1'b0;
            b_fired = 1'b0;
            if (!bus.bvalid && s_bpend > 0 && $urandom_range(0, 1) == 1) bus.bvalid = 1'b1;
            #2;
            if (reset) begin
                s_rq.delete(); s_wq.delete();
                s_rbeat = 0; s_wbeat = 0; s_bpend = 0;
                bus.rvalid = 1'b0; bus.bvalid = 1'b0;
            end else begin
                if (bus.arvalid && bus.arready) s_rq.push_back({bus.araddr, bus.arlen});
                if (bus.rvalid && bus.rready && s_rq.size() > 0) begin
                    r_fired = 1'b1;
                    cur = s_rq[0];
                    if (s_rbeat == int'(cur[7:0])) begin
                        void'(s_rq.pop_front());
                        s_rbeat = 0;
                    end else s_rbeat++;
                end
                if (bus.awvalid && bus.awready) s_wq.push_back({bus.awaddr, bus.awlen});
                if (bus.wvalid && bus.wready && s_wq.size() > 0) begin
                    cur  = s_wq[0];
                    widx = (cur[39:8] >> 2) + s_wbeat;
                    smem[widx] = merge(slv_rd(widx), bus.wdata, bus.wstrb);
                    if (s_wbeat == int'(cur[7:0])) begin
                        void'(s_wq.pop_front());
                        s_wbeat = 0;
                        s_bpend++;
                    end else s_wbeat++;
                end
                if (bus.bvalid && bus.bready) begin
                    b_fired = 1'b1;
                    s_bpend--;
                end
            end
        end
    end

    // Monitor: ready rules mid-cycle, then every handshake against the expectation queues
    logic        ar_wait = 1'b0, w_wait = 1'b0;
    logic [31:0] ar_prev = '0, wd_prev = '0;
    initial begin
        logic        exp_rd;
        logic [39:0] ea;
        logic [32:0] er;
        logic [36:0] ew;
        forever begin
            @(negedge clk_g);
            #1;
            if (!reset) begin
                exp_rd = !rd_busy && !(wr_busy && bus.rd_addr[31:4] == wr_line)
                         && !(bus.wr_req && bus.wr_addr[31:4] == bus.rd_addr[31:4]);
                check("rd_rdy", 64'(bus.rd_rdy), 64'(exp_rd));
                check("wr_rdy", 64'(bus.wr_rdy), 64'(!wr_busy));
            end
            #2;
            if (reset) begin
                ar_wait = 1'b0;
                w_wait  = 1'b0;
            end else begin
                if (ar_wait) begin
                    check("arvalid_hold", 64'(bus.arvalid), 64'd1);
                    check("araddr_hold", 64'(bus.araddr), 64'(ar_prev));
                end
                if (bus.arvalid && bus.arready) begin
                    if (exp_ar.size() == 0) check("ar_unexpected", 64'(bus.araddr), 64'hDEAD);
                    else begin
                        ea = exp_ar.pop_front();
                        check("araddr", 64'(bus.araddr), 64'(ea[39:8]));
                        check("arlen", 64'(bus.arlen), 64'(ea[7:0]));
                    end
                end
                ar_wait = bus.arvalid && !bus.arready;
                ar_prev = bus.araddr;
                if (bus.rvalid) check("rready", 64'(bus.rready), 64'd1);
                if (bus.ret_valid) begin
                    if (exp_ret.size() == 0) check("ret_unexpected", 64'(bus.ret_data), 64'hDEAD);
                    else begin
                        er = exp_ret.pop_front();
                        check("ret_data", 64'(bus.ret_data), 64'(er[31:0]));
                        check("ret_last", 64'(bus.ret_last), 64'(er[32]));
                        if (er[32]) rd_busy = 1'b0;
                    end
                end
                if (bus.awvalid && bus.awready) begin
                    if (exp_aw.size() == 0) check("aw_unexpected", 64'(bus.awaddr), 64'hDEAD);
                    else begin
                        ea = exp_aw.pop_front();
                        check("awaddr", 64'(bus.awaddr), 64'(ea[39:8]));
                        check("awlen", 64'(bus.awlen), 64'(ea[7:0]));
                    end
                end
                if (w_wait) begin
                    check("wvalid_hold", 64'(bus.wvalid), 64'd1);
                    check("wdata_hold", 64'(bus.wdata), 64'(wd_prev));
                end
                if (bus.wvalid && bus.wready) begin
                    if (exp_w.size() == 0) check("w_unexpected", 64'(bus.wdata), 64'hDEAD);
                    else begin
                        ew = exp_w.pop_front();
                        check("wdata", 64'(bus.wdata), 64'(ew[31:0]));
                        check("wstrb", 64'(bus.wstrb), 64'(ew[35:32]));
                        check("wlast", 64'(bus.wlast), 64'(ew[36]));
                    end
                    w_fires++;
                end
                w_wait  = bus.wvalid && !bus.wready;
                wd_prev = bus.wdata;
                if (bus.bvalid && bus.bready) begin
                    check("b_after_all_beats", 64'(exp_w.size()), 64'd0);
                    wr_busy = 1'b0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic        rd_pend, wr_pend, is_line;
        logic [31:0] la;
        int          base;
        rd_pend = 1'b0; wr_pend = 1'b0;
        bus.rd_req = 1'b0; bus.rd_type = 3'b010; bus.rd_addr = '0;
        bus.wr_req = 1'b0; bus.wr_type = 3'b010; bus.wr_addr = 32'hFFFF_FFF0;
        bus.wr_wstrb = '0; bus.wr_data = '0;

        repeat (3) @(negedge clk_g);
        #2;
        check("rst_arvalid", 64'(bus.arvalid), 64'd0);
        check("rst_rready",  64'(bus.rready),  64'd0);
        check("rst_awvalid", 64'(bus.awvalid), 64'd0);
        check("rst_wvalid",  64'(bus.wvalid),  64'd0);
        check("rst_wlast",   64'(bus.wlast),   64'd0);
        check("rst_bready",  64'(bus.bready),  64'd0);
        @(negedge clk_g);
        reset = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_g);
            bus.rd_req = rd_pend;
            bus.wr_req = wr_pend;
            if (!rd_pend && $urandom_range(0, 2) == 0) begin
                la      = pick_line();
                is_line = ($urandom_range(0, 1) == 1);
                bus.rd_type = is_line ? 3'b100 : 3'b010;
                bus.rd_addr = is_line ? la : la + 32'(4 * $urandom_range(0, 3));
                bus.rd_req  = 1'b1;
                rd_pend     = 1'b1;
            end
            if (!wr_pend && $urandom_range(0, 2) == 0) begin
                la = pick_line();
                if (!(rd_busy && rd_line == la[31:4])) begin
                    is_line      = ($urandom_range(0, 1) == 1);
                    bus.wr_type  = is_line ? 3'b100 : 3'b010;
                    bus.wr_addr  = is_line ? la : la + 32'(4 * $urandom_range(0, 3));
                    bus.wr_wstrb = 4'($urandom_range(0, 15));
                    bus.wr_data  = {$urandom, $urandom, $urandom, $urandom};
                    bus.wr_req   = 1'b1;
                    wr_pend      = 1'b1;
                end
            end
            #2;
            if (bus.wr_req && bus.wr_rdy) begin
                model_write(bus.wr_addr, bus.wr_type == 3'b100, bus.wr_wstrb, bus.wr_data);
                wr_pend = 1'b0;
            end
            if (bus.rd_req && bus.rd_rdy) begin
                model_read(bus.rd_addr, bus.rd_type == 3'b100);
                rd_pend = 1'b0;
            end
        end
        @(negedge clk_g);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        drain();

        // Line write abandoned by reset on its second data beat
        @(negedge clk_g);
        base         = w_fires;
        bus.wr_addr  = 32'h1C000040;
        bus.wr_type  = 3'b100;
        bus.wr_wstrb = 4'h0;
        bus.wr_data  = 128'h44444444_33333333_22222222_11111111;
        bus.wr_req   = 1'b1;
        #2;
        check("wr_rdy_idle", 64'(bus.wr_rdy), 64'd1);
        if (bus.wr_rdy) model_write(bus.wr_addr, 1'b1, 4'h0, bus.wr_data);
        @(negedge clk_g);
        bus.wr_req = 1'b0;
        for (int k = 0; k < 300 && w_fires < base + 1; k++) @(negedge clk_g);
        check("first_w_beat_seen", 64'(w_fires >= base + 1), 64'd1);
        reset = 1'b1;
        exp_w.delete();
        exp_aw.delete();
        wr_busy = 1'b0;
        @(negedge clk_g);
        reset = 1'b0;
        #2;
        check("post_rst_wvalid", 64'(bus.wvalid), 64'd0);
        check("post_rst_wlast",  64'(bus.wlast),  64'd0);
        check("post_rst_wr_rdy", 64'(bus.wr_rdy), 64'd1);
        check("post_rst_rd_rdy", 64'(bus.rd_rdy), 64'd1);

        // Fresh line read after the reset
        @(negedge clk_g);
        bus.rd_addr = 32'h1C000010;
        bus.rd_type = 3'b100;
        bus.rd_req  = 1'b1;
        #2;
        check("fresh_rd_rdy", 64'(bus.rd_rdy), 64'd1);
        if (bus.rd_rdy) model_read(bus.rd_addr, 1'b1);
        @(negedge clk_g);
        bus.rd_req = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 clk_g  in  1  sole clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 rd_req  in  1  cache read request.
REQ-004 rd_type  in  3  3'b100 = 4-word line read; 3'b010 = single-word read.
REQ-005 rd_addr  in  32  read start address.
REQ-006 rd_rdy  out  1  read request accepted when rd_req && rd_rdy.
REQ-007 ret_valid  out  1  returned read word valid.
REQ-008 ret_last  out  1  final returned word.
REQ-009 ret_data  out  32  returned read word.
REQ-010 wr_req  in  1  cache write request.
REQ-011 wr_type  in  3  3'b100 = 4-word line write; 3'b010 = single-word write.
REQ-012 wr_addr  in  32  write start address.
REQ-013 wr_wstrb  in  4  byte strobes; used only for single-word writes.
REQ-014 wr_data  in  128  write data; word 0 in [31:0].
REQ-015 wr_rdy  out  1  write request accepted when wr_req && wr_rdy.
REQ-016 araddr  out  32  AXI read address.
REQ-017 arlen  out  8  AXI read burst length minus one.
REQ-018 arvalid  out  1  AXI read address valid.
REQ-019 arready  in  1  AXI read address ready.
REQ-020 rdata  in  32  AXI read data.
REQ-021 rlast  in  1  AXI last read beat.
REQ-022 rvalid  in  1  AXI read data valid.
REQ-023 rready  out  1  AXI read data ready.
REQ-024 awaddr  out  32  AXI write address.
REQ-025 awlen  out  8  AXI write burst length minus one.
REQ-026 awvalid  out  1  AXI write address valid.
REQ-027 awready  in  1  AXI write address ready.
REQ-028 wdata  out  32  AXI write data.
REQ-029 wstrb  out  4  AXI write strobes.
REQ-030 wlast  out  1  AXI last write beat.
REQ-031 wvalid  out  1  AXI write data valid.
REQ-032 wready  in  1  AXI write data ready.
REQ-033 bvalid  in  1  AXI write response valid.
REQ-034 bready  out  1  AXI write response ready.
REQ-035 No parameters. ID, burst, size, cache and prot are tied by the top-level wrapper: ID 0, INCR, 4-byte.

Function
REQ-036 Read FSM R_IDLE -> R_AR -> R_DATA -> R_IDLE.
- Acceptance latches rd_addr into araddr; arlen = 8'd3 when rd_type == 3'b100, else 8'd0.
- R_AR: arvalid = 1 and held stable until arready.
- R_DATA: rready = 1; ret_valid = rvalid, ret_data = rdata, ret_last = rlast, all combinational, zero added latency.
- The beat with rvalid && rlast returns the FSM to R_IDLE.
REQ-037 Write FSM W_IDLE -> W_AW -> W_DATA -> W_RESP -> W_IDLE.
- wr_rdy = 1 only in W_IDLE.
- Acceptance latches address, 128-bit data, strobes and length; awlen = 3 for a line write, else 0.
REQ-038 Write channel behaviour:
- W_AW: awvalid = 1 until awready.
- W_DATA: wvalid = 1; a 2-bit beat counter starting at 0 selects wdata = data[cnt*32 +: 32] and advances on each wvalid && wready.
- wstrb = 4'hF for line writes, else the latched wr_wstrb; wlast = 1 when cnt == awlen[1:0].
- The wlast handshake enters W_RESP; bready = 1 there until bvalid, then W_IDLE.
REQ-039 rd_rdy = R_IDLE && no line hazard.
- A line hazard exists when rd_addr[31:4] equals the latched write address [31:4] while the write FSM is not in W_IDLE.
- A line hazard also exists when wr_req is asserted in the same cycle with equal wr_addr[31:4].
- Reads to other lines proceed concurrently with an outstanding write.
REQ-040 All AXI valid outputs are registered and never depend combinationally on the corresponding ready; rresp and bresp are ignored.

Reset
REQ-041 While reset = 1: both FSMs enter IDLE; arvalid, rready, awvalid, wvalid, wlast and bready = 0; rd_rdy and wr_rdy = 1 on the first cycle after reset; a reset mid-burst abandons the transaction with no further beats driven.

Verification
REQ-042 Line read 0x1C000010, arready delayed 3 cycles -> arvalid held 3 cycles with araddr 0x1C000010 and arlen 3; 4 ret_valid beats; ret_last only on beat 4; rd_rdy = 1 the following cycle.
REQ-043 Line write of data 0x...44444444_33333333_22222222_11111111 with wready toggling -> wdata sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444; wstrb 4'hF; wlast on the 4th beat only; bready until bvalid.
REQ-044 Word write 0x80000004 with wstrb 4'b0011 -> awlen 0, one beat with wstrb 4'b0011 and wlast = 1.
REQ-045 Write to line 0x1C000040 outstanding, rd_req to 0x1C000048 -> rd_rdy = 0 until the B handshake; a concurrent rd_req to 0x1C000080 is accepted immediately.
REQ-046 Reset asserted during the 2nd W beat -> next cycle wvalid = 0, wr_rdy = 1, rd_rdy = 1; a fresh read then completes normally.
